divisor_restauracion: RTL and testbench

Sequential unsigned restoring divider: the division counterpart of the team's shift-and-add multiplier. It contains its own datapath (A, Q and M registers) and control unit. Each quotient bit takes one shift state and one subtract/restore state. The block sits beside the multiplier in the arithmetic unit and uses the same start/fin handshake.

---
 rtl/divisor_restauracion.sv | 113 +++++++++++
 tb/tb_divisor_restauracion.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/divisor_restauracion.sv
// Sequential unsigned restoring divider (A/Q/M datapath plus control FSM).
// Optional macro DIV_CERO_DETECT_EN: short-circuits a zero divisor straight to FIN with div_cero=1.
module divisor_restauracion #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] cociente,
  output logic [N-1:0] resto,
  output logic         ocupado,
  output logic         fin,
  output logic         div_cero
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, DESPLAZA, RESTA, FIN} state_t;

  state_t        state_q, state_d;
  logic [N:0]    a_q, a_d;
  logic [N:0]    resta_t;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef DIV_CERO_DETECT_EN
  logic          dz_q, dz_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
`ifdef DIV_CERO_DETECT_EN
    dz_d    = dz_q;
`endif
    resta_t = a_q - {1'b0, m_q};

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          a_d     = '0;
          q_d     = dividendo;
          m_d     = divisor;
          cnt_d   = '0;
          state_d = DESPLAZA;
`ifdef DIV_CERO_DETECT_EN
          dz_d    = 1'b0;
          if (divisor == '0) begin
            a_d     = {1'b0, dividendo};
            q_d     = '1;
            dz_d    = 1'b1;
            state_d = FIN;
          end
`endif
        end
      end
      DESPLAZA: begin
        a_d     = {a_q[N-1:0], q_q[N-1]};
        q_d     = {q_q[N-2:0], 1'b0};
        state_d = RESTA;
      end
      RESTA: begin
        // A negative trial difference means restore: keep A, quotient bit stays 0.
        if (!resta_t[N]) begin
          a_d = resta_t;
        end
        q_d     = {q_q[N-1:1], ~resta_t[N]};
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == LAST) ? FIN : DESPLAZA;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
`ifdef DIV_CERO_DETECT_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
`ifdef DIV_CERO_DETECT_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign cociente = q_q;
  assign resto    = a_q[N-1:0];
  assign ocupado  = (state_q == DESPLAZA) || (state_q == RESTA);
  assign fin      = (state_q == FIN);
`ifdef DIV_CERO_DETECT_EN
  assign div_cero = dz_q;
`else
  assign div_cero = 1'b0;
`endif

endmodule

// File: tb/tb_divisor_restauracion.sv
// Self-checking bench for divisor_restauracion (N=4): directed vector table plus
// hand-written sequences for abort, ignored start and back-to-back operation.
module tb_divisor_restauracion;

  localparam int N = 4;
`ifdef DIV_CERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] dividendo;
  logic [N-1:0] divisor;
  logic [N-1:0] cociente;
  logic [N-1:0] resto;
  logic         ocupado;
  logic         fin;
  logic         div_cero;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    int dvd;
    int dvs;
    int expQ;
    int expR;
  } vec_t;

  divisor_restauracion #(.N(N)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dividendo(dividendo),
    .divisor(divisor),
    .cociente(cociente),
    .resto(resto),
    .ocupado(ocupado),
    .fin(fin),
    .div_cero(div_cero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Launches one operation and counts edges until fin, bounded so a stuck DUT cannot hang the run.
  task automatic applyStimulus(input int dvd, input int dvs, output int latency, output int busy);
    @(negedge clk);
    dividendo = dvd[N-1:0];
    divisor   = dvs[N-1:0];
    start     = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    latency = 0;
    busy    = 0;
    while (!fin && latency < 40) begin
      if (ocupado) busy++;
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    int lat, busy, expLat;
    bit dz;

    vecs[0] = '{13, 4, 3, 1};
    vecs[1] = '{3, 7, 0, 3};
    vecs[2] = '{15, 1, 15, 0};
    vecs[3] = '{9, 0, 15, 9};
    vecs[4] = '{14, 3, 4, 2};
    vecs[5] = '{12, 5, 2, 2};
    vecs[6] = '{0, 5, 0, 0};
    vecs[7] = '{15, 15, 1, 0};
    vecs[8] = '{7, 2, 3, 1};
    vecs[9] = '{1, 15, 0, 1};

    reset     = 1'b1;
    start     = 1'b0;
    dividendo = '0;
    divisor   = '0;
    #12;
    checkOutput("reset cociente", int'(cociente), 0);
    checkOutput("reset resto", int'(resto), 0);
    checkOutput("reset ocupado", int'(ocupado), 0);
    checkOutput("reset fin", int'(fin), 0);
    checkOutput("reset div_cero", int'(div_cero), 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      dz     = DZ_EN && (vecs[i].dvs == 0);
      expLat = dz ? 0 : 2 * N;
      applyStimulus(vecs[i].dvd, vecs[i].dvs, lat, busy);
      checkOutput($sformatf("vec%0d latency", i), lat, expLat);
      checkOutput($sformatf("vec%0d ocupado cycles", i), busy, dz ? 0 : 2 * N);
      checkOutput($sformatf("vec%0d cociente", i), int'(cociente), vecs[i].expQ);
      checkOutput($sformatf("vec%0d resto", i), int'(resto), vecs[i].expR);
      checkOutput($sformatf("vec%0d div_cero", i), int'(div_cero), dz ? 1 : 0);
    end

    // start pulsed mid-operation must be ignored
    @(negedge clk);
    dividendo = 4'd12;
    divisor   = 4'd5;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start     = 1'b1;
    dividendo = 4'd15;
    divisor   = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ignore ocupado", int'(ocupado), 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ignore fin early", int'(fin), 0);
    @(posedge clk);
    #1;
    checkOutput("ignore fin", int'(fin), 1);
    checkOutput("ignore cociente", int'(cociente), 2);
    checkOutput("ignore resto", int'(resto), 2);

    // Asynchronous reset mid-operation aborts immediately
    @(negedge clk);
    dividendo = 4'd14;
    divisor   = 4'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort busy before reset", int'(ocupado), 1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort cociente", int'(cociente), 0);
    checkOutput("abort resto", int'(resto), 0);
    checkOutput("abort ocupado", int'(ocupado), 0);
    checkOutput("abort fin", int'(fin), 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(14, 3, lat, busy);
    checkOutput("after abort latency", lat, 2 * N);
    checkOutput("after abort cociente", int'(cociente), 4);
    checkOutput("after abort resto", int'(resto), 2);

    // Back-to-back sweep with start held high: one result every 2N+1 edges
    @(negedge clk);
    start = 1'b1;
    for (int d = 1; d < 16; d++) begin
      for (int x = 0; x < 16; x++) begin
        dividendo = x[N-1:0];
        divisor   = d[N-1:0];
        @(posedge clk);
        repeat (2 * N - 1) @(posedge clk);
        #1;
        checkOutput($sformatf("sweep %0d/%0d fin low", x, d), int'(fin), 0);
        @(posedge clk);
        #1;
        checkOutput($sformatf("sweep %0d/%0d fin", x, d), int'(fin), 1);
        checkOutput($sformatf("sweep %0d/%0d cociente", x, d), int'(cociente), x / d);
        checkOutput($sformatf("sweep %0d/%0d resto", x, d), int'(resto), x % d);
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("fin holds after sweep", int'(fin), 1);
    checkOutput("result holds after sweep", int'(cociente), 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
